// File: rtl/cache_pkg.sv
// Shared types and helpers for the read-only cache: FSM state encoding,
// address-field width helpers and the line word selector.
package cache_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_t;

  // Lines up to this many 32-bit words are supported by word_sel.
  localparam int MAX_LINE_WORDS = 64;
  localparam int MAX_LINE_BITS  = 32 * MAX_LINE_WORDS;

  function automatic int woff_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - 2 - $clog2(sets) - $clog2(line_words);
  endfunction

  // Callers zero-extend their line to MAX_LINE_BITS before selecting.
  function automatic logic [31:0] word_sel(input logic [MAX_LINE_BITS-1:0] line,
                                           input logic [5:0] woff);
    return line[{woff, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid/tag/data storage with a combinational
// lookup (tag compare + word read) and a synchronous full-line write port.
module cache_way
  import cache_pkg::*;
#(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24,
  parameter int IDX_W      = 4,
  parameter int WOFF_W     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic [IDX_W-1:0]        i_rd_idx,
  input  logic [TAG_W-1:0]        i_rd_tag,
  input  logic [WOFF_W-1:0]       i_rd_woff,
  output logic                    o_valid,
  output logic                    o_hit,
  output logic [31:0]             o_word,
  input  logic                    i_wr_en,
  input  logic [IDX_W-1:0]        i_wr_idx,
  input  logic [TAG_W-1:0]        i_wr_tag,
  input  logic [32*LINE_WORDS-1:0] i_wr_line
);

  localparam int LINE_BITS = 32 * LINE_WORDS;

  logic [SETS-1:0]      r_valid;
  logic [TAG_W-1:0]     r_tag  [SETS];
  logic [LINE_BITS-1:0] r_data [SETS];
  logic [MAX_LINE_BITS-1:0] w_line_ext;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data contents survive reset and flush; only valid bits matter.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_line;
    end
  end

  assign o_valid = r_valid[i_rd_idx];
  assign o_hit   = o_valid && (r_tag[i_rd_idx] == i_rd_tag);

  always_comb begin
    w_line_ext = '0;
    w_line_ext[LINE_BITS-1:0] = r_data[i_rd_idx];
  end

  assign o_word = word_sel(w_line_ext, 6'(i_rd_woff));

endmodule

// File: rtl/param_read_cache.sv
// Read-only set-associative cache (1 or 2 ways, LRU) with a valid/ready CPU
// port and a single-outstanding line refill port toward backing memory.
module param_read_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     req_ready,
  input  logic                     flush,
  output logic                     resp_valid,
  output logic [31:0]              resp_data,
  output logic                     resp_hit,
  output logic                     mem_req_valid,
  output logic [ADDR_W-1:0]        mem_req_addr,
  input  logic                     mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_resp_data
);

  localparam int WOFF_W     = woff_w(LINE_WORDS);
  localparam int IDX_W      = idx_w(SETS);
  localparam int TAG_W      = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int LINE_BITS  = 32 * LINE_WORDS;
  localparam int LINE_SHIFT = 2 + WOFF_W;

  state_t r_state, w_state_next;

  logic [ADDR_W-1:2]  r_miss_addr;
  logic               r_resp_valid, r_resp_hit, r_mem_req_valid;
  logic [31:0]        r_resp_data;
  logic [ADDR_W-1:0]  r_mem_req_addr;

  logic [ADDR_W-1:2]  w_lookup_addr;
  logic [WOFF_W-1:0]  w_woff;
  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [WAYS-1:0]    w_way_valid, w_way_hit, w_victim_oh;
  logic [31:0]        w_way_word [WAYS];
  logic [31:0]        w_hit_word;
  logic               w_hit, w_accept, w_fill, w_clear, w_req_ready;
  logic [MAX_LINE_BITS-1:0] w_mem_line_ext;
  logic               w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = &{1'b0, req_addr[1:0]};

  // While a refill is outstanding the ways are probed with the missed address.
  assign w_lookup_addr = (r_state == S_MISS) ? r_miss_addr : req_addr[ADDR_W-1:2];
  assign w_woff = w_lookup_addr[2 +: WOFF_W];
  assign w_idx  = w_lookup_addr[LINE_SHIFT +: IDX_W];
  assign w_tag  = w_lookup_addr[LINE_SHIFT+IDX_W +: TAG_W];
  assign w_hit  = |w_way_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_accept     = 1'b0;
    w_fill       = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = !flush;
        w_clear     = flush;
        w_accept    = req_valid && !flush;
        if (w_accept && !w_hit) begin
          w_state_next = S_MISS;
        end
      end
      S_MISS: begin
        if (mem_resp_valid) begin
          w_fill       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign req_ready = w_req_ready;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    cache_way #(
      .SETS      (SETS),
      .LINE_WORDS(LINE_WORDS),
      .TAG_W     (TAG_W),
      .IDX_W     (IDX_W),
      .WOFF_W    (WOFF_W)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_clear),
      .i_rd_idx (w_idx),
      .i_rd_tag (w_tag),
      .i_rd_woff(w_woff),
      .o_valid  (w_way_valid[gi]),
      .o_hit    (w_way_hit[gi]),
      .o_word   (w_way_word[gi]),
      .i_wr_en  (w_fill && !rst && w_victim_oh[gi]),
      .i_wr_idx (w_idx),
      .i_wr_tag (w_tag),
      .i_wr_line(mem_resp_data)
    );
  end

  if (WAYS == 2) begin : g_lru
    // r_lru[set] names the least recently used way of that set.
    logic [SETS-1:0] r_lru;
    logic            w_victim;

    assign w_victim    = !w_way_valid[0] ? 1'b0 :
                         (!w_way_valid[1] ? 1'b1 : r_lru[w_idx]);
    assign w_victim_oh = {w_victim, !w_victim};
    assign w_hit_word  = w_way_hit[1] ? w_way_word[1] : w_way_word[0];

    always_ff @(posedge clk) begin
      if (rst || w_clear) begin
        r_lru <= '0;
      end else if (w_accept && w_hit) begin
        r_lru[w_idx] <= !w_way_hit[1];
      end else if (w_fill) begin
        r_lru[w_idx] <= !w_victim;
      end
    end
  end else begin : g_direct
    logic w_unused_valid;
    assign w_unused_valid = &{1'b0, w_way_valid};
    assign w_victim_oh    = '1;
    assign w_hit_word     = w_way_word[0];
  end

  always_comb begin
    w_mem_line_ext = '0;
    w_mem_line_ext[LINE_BITS-1:0] = mem_resp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid    <= 1'b0;
      r_resp_hit      <= 1'b0;
      r_resp_data     <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_miss_addr     <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept && w_hit) begin
        r_resp_valid <= 1'b1;
        r_resp_hit   <= 1'b1;
        r_resp_data  <= w_hit_word;
      end
      if (w_accept && !w_hit) begin
        r_miss_addr     <= req_addr[ADDR_W-1:2];
        r_mem_req_valid <= 1'b1;
        r_mem_req_addr  <= {req_addr[ADDR_W-1:LINE_SHIFT], {LINE_SHIFT{1'b0}}};
      end
      if (w_fill) begin
        r_mem_req_valid <= 1'b0;
        r_resp_valid    <= 1'b1;
        r_resp_hit      <= 1'b0;
        r_resp_data     <= word_sel(w_mem_line_ext, 6'(w_woff));
      end
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_hit      = r_resp_hit;
  assign resp_data     = r_resp_data;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_mem_req_addr;

endmodule

// File: tb/tb_param_read_cache.sv
// Bench for param_read_cache: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a recency-list model.
module tb_param_read_cache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, req_valid, flush, mem_resp_valid;
  logic [31:0]  req_addr;
  logic [127:0] mem_resp_data;
  logic         req_ready, resp_valid, resp_hit, mem_req_valid;
  logic [31:0]  resp_data, mem_req_addr;

  logic         u1_req_valid, u1_flush, u1_mem_resp_valid;
  logic [31:0]  u1_req_addr;
  logic [127:0] u1_mem_resp_data;
  logic         u1_req_ready, u1_resp_valid, u1_resp_hit, u1_mem_req_valid;
  logic [31:0]  u1_resp_data, u1_mem_req_addr;

  param_read_cache #(.ADDR_W(32), .SETS(16), .WAYS(2), .LINE_WORDS(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush), .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  param_read_cache #(.ADDR_W(32), .SETS(16), .WAYS(1), .LINE_WORDS(4)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(u1_req_valid), .req_addr(u1_req_addr), .req_ready(u1_req_ready),
    .flush(u1_flush), .resp_valid(u1_resp_valid), .resp_data(u1_resp_data), .resp_hit(u1_resp_hit),
    .mem_req_valid(u1_mem_req_valid), .mem_req_addr(u1_mem_req_addr),
    .mem_resp_valid(u1_mem_resp_valid), .mem_resp_data(u1_mem_resp_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (wa == 32'h64) return 32'h1111_1111;
    return {wa[15:0] ^ wa[31:16], ~wa[15:0]};
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = mem_word({la[31:4], 4'b0} + 32'(4*i));
    return l;
  endfunction

  // Memory responder: random refill latency, optional stray pulses while idle.
  bit mem_auto = 1'b1;
  bit stray_en = 1'b0;
  int late_req = 0;
  int late_done = 0;

  initial begin
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    u1_mem_resp_valid = 1'b0; u1_mem_resp_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      u1_mem_resp_valid = 1'b0;
      if (late_req != late_done) begin
        mem_resp_valid = 1'b1; mem_resp_data = mem_line(32'h460); late_done++;
      end else if (mem_auto && mem_req_valid && ($urandom % 3 == 0)) begin
        mem_resp_valid = 1'b1; mem_resp_data = mem_line(mem_req_addr);
      end else if (stray_en && !mem_req_valid && ($urandom % 8 == 0)) begin
        mem_resp_valid = 1'b1; mem_resp_data = {4{$urandom}};
      end
      if (u1_mem_req_valid && ($urandom % 2 == 0)) begin
        u1_mem_resp_valid = 1'b1; u1_mem_resp_data = mem_line(u1_mem_req_addr);
      end
    end
  end

  // Reference model: each set is a recency-ordered tag list (MRU first, at most 2).
  logic [23:0] m_tag [16][2];
  int          m_cnt [16];
  logic        m_busy = 1'b0;
  logic [31:0] m_addr = '0;
  logic        e_rv = 1'b0, e_rh = 1'b0, e_mv = 1'b0;
  logic [31:0] e_rd = '0, e_ma = '0;

  initial begin
    forever begin : model
      logic [3:0]  s;
      logic [23:0] t;
      int          pos;
      @(negedge clk);
      chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy && !flush});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, e_rv});
      chk("resp_hit", {31'b0, resp_hit}, {31'b0, e_rh});
      chk("resp_data", resp_data, e_rd);
      chk("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, e_mv});
      chk("mem_req_addr", mem_req_addr, e_ma);
      e_rv = 1'b0;
      if (rst) begin
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        m_busy = 1'b0; e_rh = 1'b0; e_rd = '0; e_mv = 1'b0; e_ma = '0;
      end else if (m_busy) begin
        if (mem_resp_valid) begin
          s = m_addr[7:4]; t = m_addr[31:8];
          if (m_cnt[s] < 2) m_cnt[s]++;
          for (int i = m_cnt[s] - 1; i > 0; i--) m_tag[s][i] = m_tag[s][i-1];
          m_tag[s][0] = t;
          e_rv = 1'b1; e_rh = 1'b0; e_rd = mem_word(m_addr); e_mv = 1'b0; m_busy = 1'b0;
        end
      end else if (flush) begin
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      end else if (req_valid) begin
        s = req_addr[7:4]; t = req_addr[31:8]; pos = -1;
        for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) pos = i;
        if (pos >= 0) begin
          for (int i = pos; i > 0; i--) m_tag[s][i] = m_tag[s][i-1];
          m_tag[s][0] = t;
          e_rv = 1'b1; e_rh = 1'b1; e_rd = mem_word(req_addr);
        end else begin
          m_busy = 1'b1; m_addr = req_addr; e_mv = 1'b1; e_ma = {req_addr[31:4], 4'b0};
        end
      end
    end
  end

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic h,
                         output int lat, output logic [31:0] ma);
    int n;
    bit got;
    d = '0; h = 1'b0; ma = '0; lat = 0; got = 1'b0; n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!got && lat < 50) begin
      @(negedge clk); lat++;
      if (mem_req_valid) ma = mem_req_addr;
      if (resp_valid) begin got = 1'b1; d = resp_data; h = resp_hit; end
    end
    if (!got) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic read1(input logic [31:0] a, output logic [31:0] d, output logic h);
    int n;
    bit got;
    d = '0; h = 1'b1; got = 1'b0; n = 0;
    @(posedge clk); #1;
    u1_req_valid = 1'b1; u1_req_addr = a;
    @(negedge clk);
    while (!u1_req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    u1_req_valid = 1'b0; n = 0;
    while (!got && n < 50) begin
      @(negedge clk); n++;
      if (u1_resp_valid) begin got = 1'b1; d = u1_resp_data; h = u1_resp_hit; end
    end
    if (!got) chk("u1_resp_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] d, ma;
  logic        h;
  int          lat;
  logic [31:0] b2b_a [3] = '{32'h60, 32'h68, 32'h6C};
  logic [31:0] b2b_w [3] = '{32'h0060FF9F, 32'h0068FF97, 32'h006CFF93};
  logic [31:0] t3_a  [6] = '{32'h000, 32'h100, 32'h000, 32'h200, 32'h000, 32'h100};
  logic        t3_h  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] t3_w  [6] = '{32'h0000FFFF, 32'h0100FEFF, 32'h0000FFFF,
                             32'h0200FDFF, 32'h0000FFFF, 32'h0100FEFF};
  logic [31:0] t6_a  [3] = '{32'h000, 32'h100, 32'h000};
  logic [31:0] t6_w  [3] = '{32'h0000FFFF, 32'h0100FEFF, 32'h0000FFFF};

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    u1_req_valid = 1'b0; u1_req_addr = '0; u1_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);

    // Cold miss on 0x64, then the same word hits one cycle after accept.
    do_read(32'h64, d, h, lat, ma);
    chk("t1_miss_hit", {31'b0, h}, 32'd0);
    chk("t1_miss_data", d, 32'h1111_1111);
    chk("t1_mem_addr", ma, 32'h60);
    do_read(32'h64, d, h, lat, ma);
    chk("t1_rehit", {31'b0, h}, 32'd1);
    chk("t1_rehit_lat", lat, 32'd1);
    chk("t1_rehit_data", d, 32'h1111_1111);

    // Back-to-back hits within the same line.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin req_valid = 1'b1; req_addr = b2b_a[k]; end
      else req_valid = 1'b0;
      @(negedge clk);
      if (k > 0) begin
        chk("t2_valid", {31'b0, resp_valid}, 32'd1);
        chk("t2_hit", {31'b0, resp_hit}, 32'd1);
        chk("t2_data", resp_data, b2b_w[k-1]);
      end
    end

    // LRU eviction within set 0.
    for (int k = 0; k < 6; k++) begin
      do_read(t3_a[k], d, h, lat, ma);
      chk("t3_hit", {31'b0, h}, {31'b0, t3_h[k]});
      chk("t3_data", d, t3_w[k]);
    end

    // Flush wins over a same-cycle request.
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h60;
    @(negedge clk);
    chk("t4_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("t4_no_resp", {31'b0, resp_valid}, 32'd0);
    do_read(32'h60, d, h, lat, ma);
    chk("t4_miss", {31'b0, h}, 32'd0);
    chk("t4_data", d, 32'h0060FF9F);

    // Reset while a refill is outstanding abandons it.
    mem_auto = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h460;
    @(negedge clk);
    chk("t5_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("t5_mreq", {31'b0, mem_req_valid}, 32'd1);
    chk("t5_maddr", mem_req_addr, 32'h460);
    @(negedge clk);
    chk("t5_mreq_hold", {31'b0, mem_req_valid}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_mreq_drop", {31'b0, mem_req_valid}, 32'd0);
    late_req++;
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    mem_auto = 1'b1;
    do_read(32'h60, d, h, lat, ma);
    chk("t5_miss_after_rst", {31'b0, h}, 32'd0);
    chk("t5_data", d, 32'h0060FF9F);

    // Direct-mapped instance: conflicting lines always miss.
    for (int k = 0; k < 3; k++) begin
      read1(t6_a[k], d, h);
      chk("t6_hit", {31'b0, h}, 32'd0);
      chk("t6_data", d, t6_w[k]);
    end

    // Randomized traffic with flushes, resets and stray refill pulses.
    stray_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [23:0] tg;
      @(posedge clk); #1;
      tg = 24'($urandom_range(0, 3));
      if ($urandom % 8 == 0) tg[23] = 1'b1;
      rst       = ($urandom % 300 == 0);
      flush     = ($urandom % 25 == 0);
      req_valid = ($urandom % 4 != 0);
      req_addr  = {tg, 4'($urandom_range(0, 3)), 4'($urandom)};
    end
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0; stray_en = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
